// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: round-robin arbiter feeding one shared serial delay line.
// A granted requester's word is launched LSB first, one bit per cycle, into
// a DELAY-stage pipeline, together with its owner id and a last-bit marker.
// Optional feature macro: SHIFT_ARB_PARITY_EN appends an even-parity bit
// after each word and moves the last-bit marker onto it.
module shift_arb_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DELAY = 8,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   out_bit,
  output logic                   out_vld,
  output logic [IDW-1:0]         out_id,
  output logic                   out_last
);

`ifdef SHIFT_ARB_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [IDW-1:0]   cur_id;
  logic             rst_d;
`ifdef SHIFT_ARB_PARITY_EN
  logic             par;
`endif

  logic [IDW-1:0]   win;
  logic             found;
  logic             grant_ok;
  logic             l_vld;
  logic             l_bit;
  logic             l_last;
  logic [IDW-1:0]   l_id;

  logic             p_vld  [DELAY];
  logic             p_bit  [DELAY];
  logic             p_last [DELAY];
  logic [IDW-1:0]   p_id   [DELAY];

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Grants only from IDLE; suppressed while in reset and for one cycle after.
  assign grant_ok = (state == IDLE) && !rst && !rst_d && found;

  // One-hot grant pulse for the round-robin winner.
  always_comb begin
    gnt = '0;
    if (grant_ok) gnt[win] = 1'b1;
  end

  assign busy = (state == SHIFT);

  // Launch value for pipeline stage 0: a payload bit in SHIFT, zeros in IDLE.
  always_comb begin
    l_vld  = 1'b0;
    l_bit  = 1'b0;
    l_last = 1'b0;
    l_id   = '0;
    if (state == SHIFT) begin
      l_vld  = 1'b1;
      l_id   = cur_id;
      l_last = (cnt == CW'(NBITS - 1));
`ifdef SHIFT_ARB_PARITY_EN
      l_bit  = (cnt == CW'(WIDTH)) ? par : shreg[0];
`else
      l_bit  = shreg[0];
`endif
    end
  end

  // Control FSM: capture on grant, then shift the word out one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      shreg  <= '0;
      cur_id <= '0;
      rst_d  <= 1'b1;
`ifdef SHIFT_ARB_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      rst_d <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            shreg  <= data[int'(win)*WIDTH +: WIDTH];
`ifdef SHIFT_ARB_PARITY_EN
            par    <= ^data[int'(win)*WIDTH +: WIDTH];
`endif
            cur_id <= win;
            cnt    <= '0;
            ptr    <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
            state  <= SHIFT;
          end
        end
        default: begin
          shreg <= shreg >> 1;
          if (l_last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Fixed-latency delay line; reset flushes any partially sent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        p_vld[i]  <= 1'b0;
        p_bit[i]  <= 1'b0;
        p_last[i] <= 1'b0;
        p_id[i]   <= '0;
      end
    end else begin
      p_vld[0]  <= l_vld;
      p_bit[0]  <= l_bit;
      p_last[0] <= l_last;
      p_id[0]   <= l_id;
      for (int i = 1; i < DELAY; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_bit[i]  <= p_bit[i-1];
        p_last[i] <= p_last[i-1];
        p_id[i]   <= p_id[i-1];
      end
    end
  end

  assign out_vld  = p_vld[DELAY-1];
  assign out_bit  = p_bit[DELAY-1];
  assign out_last = p_last[DELAY-1];
  assign out_id   = p_id[DELAY-1];

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl at N_REQ=4, WIDTH=8, DELAY=8.
// Define SHIFT_ARB_PARITY_EN for both bench and RTL to cover the parity bit.
module tb_shift_arb_ctrl;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int DELAY = 8;
`ifdef SHIFT_ARB_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int PER = NB + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] data = '0;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   out_bit;
  logic                   out_vld;
  logic [1:0]             out_id;
  logic                   out_last;

  int total = 0;
  int bad   = 0;

  shift_arb_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DELAY(DELAY)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .out_bit(out_bit), .out_vld(out_vld), .out_id(out_id), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_vld"},  32'(out_vld), 0);
    chk({tag, "_bit"},  32'(out_bit), 0);
    chk({tag, "_id"},   32'(out_id), 0);
    chk({tag, "_last"}, 32'(out_last), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Grant one word to requester id (ptr must favour it) and follow it out.
  task automatic xmit(input logic [WIDTH-1:0] w, input int id);
    logic exp_bit;
    req = '0;
    req[id] = 1'b1;
    data[id*WIDTH +: WIDTH] = w;
    #1;
    chk("x_gnt", 32'(gnt), 32'(1) << id);
    chk("x_busy_idle", 32'(busy), 0);
    tick();
    req = '0;
    chk("x_busy", 32'(busy), 1);
    chk("x_gnt_shift", 32'(gnt), 0);
    repeat (DELAY - 1) tick();
    chk("x_vld_pre", 32'(out_vld), 0);
    for (int b = 0; b < NB; b++) begin
      tick();
      exp_bit = (b < WIDTH) ? w[b] : ^w;
      chk("x_vld",  32'(out_vld), 1);
      chk("x_bit",  32'(out_bit), 32'(exp_bit));
      chk("x_id",   32'(out_id), 32'(id));
      chk("x_last", 32'(out_last), (b == NB - 1) ? 1 : 0);
    end
    tick();
    chk("x_vld_post", 32'(out_vld), 0);
  endtask

  initial begin
    // Reset behaviour, with requests pending throughout.
    rst = 1'b1;
    req = '1;
    tick();
    chk_idle_outs("rst_during");
    tick();
    rst = 1'b0;
    #1;
    chk_idle_outs("rst_after");
    req = '0;
    tick();
    chk("idle_nogrant", 32'(gnt), 0);

    // Single word 8'hA5 from requester 2.
    xmit(8'hA5, 2);

    // All requesting: round-robin 0,1,2,3,0 spaced PER cycles.
    do_reset();
    data = {8'hFF, 8'h42, 8'h81, 8'h3C};
    req  = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      if (k > 0) begin
        chk("rr_vld", 32'(out_vld), 1);
        chk("rr_id",  32'(out_id), 32'((k - 1) % 4));
      end
      tick();
      chk("rr_busy", 32'(busy), 1);
      chk("rr_nogrant", 32'(gnt), 0);
      repeat (NB) tick();
    end

    // Reset during the 4th bit of a word abandons it; ptr returns to 0.
    do_reset();
    req = 4'b0100;
    data[2*WIDTH +: WIDTH] = 8'hA5;
    #1;
    chk("ab_gnt", 32'(gnt), 32'h4);
    tick();
    req = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_idle_outs("ab_after");
    for (int i = 0; i < 12; i++) begin
      chk("ab_novld", 32'(out_vld), 0);
      tick();
    end
    req = 4'b1010;
    #1;
    chk("ab_ptr0", 32'(gnt), 32'h2);

    // Requests toggling while shifting never produce a grant.
    tick();
    for (int i = 0; i < NB; i++) begin
      req = (i % 2) ? 4'b1111 : 4'b0000;
      #1;
      chk("tg_busy", 32'(busy), 1);
      chk("tg_nogrant", 32'(gnt), 0);
      tick();
    end
    req = '1;
    #1;
    chk("tg_idle_gnt", 32'(gnt), 32'h4);
    chk("tg_idle_busy", 32'(busy), 0);
    tick();
    req = '0;

    // One requester held: back-to-back words with a single gap cycle.
    do_reset();
    req = 4'b0001;
    data[0 +: WIDTH] = 8'h96;
    #1;
    chk("bb_gnt0", 32'(gnt), 32'h1);
    repeat (PER) tick();
    chk("bb_gnt1", 32'(gnt), 32'h1);
    repeat (DELAY - 1) tick();
    chk("bb_lastvld", 32'(out_vld), 1);
    chk("bb_last", 32'(out_last), 1);
    tick();
    chk("bb_gap", 32'(out_vld), 0);
    tick();
    chk("bb_next_vld", 32'(out_vld), 1);
    chk("bb_next_id", 32'(out_id), 0);
    chk("bb_next_bit", 32'(out_bit), 0);
    req = '0;

`ifdef SHIFT_ARB_PARITY_EN
    // Parity bit: 8'h07 -> 1, 8'h03 -> 0.
    do_reset();
    xmit(8'h07, 0);
    xmit(8'h03, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
